ika9958_prim_flagbank: RTL
==========================

# ika9958_prim_flagbank

Parametrised bank of clock-enabled set/reset flags: the multi-bit successor to the single SR-latch primitive. Each flag has a selectable set/reset conflict priority, optional rising-edge detection on its set input, a CPU read-and-clear path with snapshot, and a masked aggregate interrupt output. It is used for VDP status/interrupt flags, such as sprite collision, 5th-sprite, line and vertical-blank flags, where hardware events set a flag and a CPU status read clears it.

## Interface
Parameters:
- WIDTH, 8: number of flags.
- PRIO, 0: conflict resolution when set and hardware reset are both asserted.
  - 0: reset wins.
  - 1: set wins.
  - 2: NOR-type invalid state, Q=0 and Q_n=0.
  - 3: hold.
- SET_EDGE, {WIDTH{1'b0}}: per-bit mode for i_S. 1 = rising-edge detect, 0 = level.
- RST_VAL, {WIDTH{1'b0}}: reset value of o_Q.

Ports:
- i_CLK  in  1  clock; the only clock.
- i_RST  in  1  reset, asynchronous, active-high.
- i_CEN  in  1  clock enable. All state advances only on i_CLK rising edges with i_CEN=1.
- i_S  in  WIDTH  per-flag set request.
- i_R  in  WIDTH  per-flag hardware reset request.
- i_RDCLR  in  1  CPU read strobe: snapshot all flags, then clear them.
- i_IE  in  WIDTH  interrupt enable mask.
- o_Q  out  WIDTH  flag state.
- o_Q_n  out  WIDTH  complementary flag state; not forced to ~o_Q in PRIO=2.
- o_SNAP  out  WIDTH  o_Q value captured by the last i_RDCLR.
- o_IRQ  out  1  registered OR of (flag & i_IE).

## Operation
- **Set term s[i]:**
  - Level mode: s[i] = i_S[i].
  - Edge mode: s[i] = i_S[i] & ~prev[i].
  - prev[i] samples i_S[i] only on i_CEN cycles and resets to 1. An input already high at reset release therefore produces no edge.
- **Per-bit next state, evaluated in priority order on each i_CEN cycle:**
  1. s & i_R: per PRIO.
     - 0: Q=0, Q_n=1.
     - 1: Q=1, Q_n=0.
     - 2: Q=0, Q_n=0.
     - 3: hold both.
  2. s only: Q=1, Q_n=0.
  3. i_R only: Q=0, Q_n=1.
  4. i_RDCLR only: Q=0, Q_n=1.
  5. Otherwise: hold both.
- **Read-clear race rule:**
  - A set in the same cycle as i_RDCLR leaves the flag set, so the event is never lost.
  - That set is not included in o_SNAP, which captures pre-update o_Q.
- **PRIO=2 invalid state (Q=0, Q_n=0):**
  - Persists under hold.
  - Resolved only by a lone set, a lone i_R, or i_RDCLR (which gives Q=0, Q_n=1).
- **o_SNAP:** loaded with the current o_Q on i_CEN & i_RDCLR; otherwise holds.
- **o_IRQ:** loaded each i_CEN cycle with |(Q_next & i_IE).
  - Aligned with the o_Q update.
  - i_IE changes during i_CEN=0 take effect at the next i_CEN cycle.
- **i_CEN=0:** every register holds. i_S, i_R and i_RDCLR are ignored; strobes must be held across an enabled edge.

## Timing
- Latency from an enabled edge where a request is sampled to the o_Q / o_Q_n / o_SNAP / o_IRQ update: 1 i_CLK edge.
- Edge mode: an i_S edge is seen by i_CEN sampling, not by i_CLK sampling. A pulse between enables is lost.
- Reset values, applied asynchronously and held while i_RST=1:
  - o_Q = RST_VAL.
  - o_Q_n = ~RST_VAL.
  - o_SNAP = 0.
  - o_IRQ = 0 (even if RST_VAL & i_IE ≠ 0, until the first i_CEN cycle).
  - prev = all-ones.
- Reset asserted mid-operation overrides any pending set or clear immediately. No output glitches other than to the reset values.
- All outputs are registered; no combinational path from input to output.

## Test plan
- **Reset / idle:** WIDTH=8, RST_VAL=8'h81; assert i_RST, then release with i_CEN=1 and inputs 0.
  - -> o_Q=8'h81, o_Q_n=8'h7E, o_SNAP=0, o_IRQ=0.
  - With i_IE=8'h01 -> o_IRQ=1 after the first i_CEN edge.
- **Conflict priority:** i_S=i_R=8'h01 for one enabled cycle, starting from Q[0]=1, Q_n[0]=0.
  - PRIO=0 -> Q[0]=0, Q_n[0]=1.
  - PRIO=1 -> Q[0]=1, Q_n[0]=0.
  - PRIO=2 -> Q[0]=0, Q_n[0]=0, persisting under 3 idle cycles.
  - PRIO=3 -> Q[0]=1, Q_n[0]=0 (held).
- **Read-clear race:** o_Q=8'h0C, then i_RDCLR=1 with i_S=8'h01 in the same enabled cycle.
  - -> o_SNAP=8'h0C, o_Q=8'h01.
- **Edge mode:** SET_EDGE=8'h01.
  - Hold i_S[0]=1 across reset release -> Q[0] stays 0.
  - Drop i_S[0] to 0, then raise it -> Q[0]=1 one edge later.
  - Clear via i_RDCLR while i_S[0] is still high -> Q[0]=0 and stays 0.
- **Clock enable gating:** i_CEN=0 while i_S=8'hFF and i_RDCLR=1 over 5 clocks -> all outputs unchanged. Hold i_S=8'hFF with i_RDCLR=0 and raise i_CEN for one clock -> o_Q=8'hFF.
- **Async reset mid-event:** assert i_RST between clock edges while i_S=8'hFF -> outputs take reset values before the next edge, and stay there until release.

Source files
------------

// File: rtl/ika9958_prim_flagbank_if.sv
// Signal bundle for the flag bank: event/CPU requests in, flag state and interrupt out.
// Master drives the requests; slave is the flag bank itself.
interface ika9958_prim_flagbank_if #(
    parameter int unsigned WIDTH = 8
);
    logic             i_CEN;
    logic [WIDTH-1:0] i_S;
    logic [WIDTH-1:0] i_R;
    logic             i_RDCLR;
    logic [WIDTH-1:0] i_IE;
    logic [WIDTH-1:0] o_Q;
    logic [WIDTH-1:0] o_Q_n;
    logic [WIDTH-1:0] o_SNAP;
    logic             o_IRQ;

    modport master (
        output i_CEN, i_S, i_R, i_RDCLR, i_IE,
        input  o_Q, o_Q_n, o_SNAP, o_IRQ
    );

    modport slave (
        input  i_CEN, i_S, i_R, i_RDCLR, i_IE,
        output o_Q, o_Q_n, o_SNAP, o_IRQ
    );
endinterface

// File: rtl/ika9958_prim_flagbank.sv
// Clock-enabled bank of set/reset status flags with CPU read-and-clear snapshot
// and a masked, registered interrupt output.
module ika9958_prim_flagbank #(
    parameter int unsigned      WIDTH    = 8,
    parameter int unsigned      PRIO     = 0,
    parameter logic [WIDTH-1:0] SET_EDGE = '0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    ika9958_prim_flagbank_if.slave bus
);
    typedef enum logic [1:0] {
        PRIO_RST_WINS = 2'd0,
        PRIO_SET_WINS = 2'd1,
        PRIO_INVALID  = 2'd2,
        PRIO_HOLD     = 2'd3
    } prio_e;

    localparam logic [1:0] PRIO_BITS = PRIO[1:0];
    localparam prio_e      PRIO_MODE = prio_e'(PRIO_BITS);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic [WIDTH-1:0] snap;
    logic             irq;
    logic [WIDTH-1:0] prev;

    logic [WIDTH-1:0] set_term;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] q_n_nxt;

    // prev resets to all-ones so an input already high at reset release is not an edge
    assign set_term = bus.i_S & ~(SET_EDGE & prev);

    always_comb begin
        q_nxt   = q;
        q_n_nxt = q_n;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (set_term[i] && bus.i_R[i]) begin
                unique case (PRIO_MODE)
                    PRIO_RST_WINS: begin q_nxt[i] = 1'b0; q_n_nxt[i] = 1'b1; end
                    PRIO_SET_WINS: begin q_nxt[i] = 1'b1; q_n_nxt[i] = 1'b0; end
                    PRIO_INVALID:  begin q_nxt[i] = 1'b0; q_n_nxt[i] = 1'b0; end
                    PRIO_HOLD:     begin q_nxt[i] = q[i]; q_n_nxt[i] = q_n[i]; end
                endcase
            end else if (set_term[i]) begin
                q_nxt[i]   = 1'b1;
                q_n_nxt[i] = 1'b0;
            end else if (bus.i_R[i] || bus.i_RDCLR) begin
                q_nxt[i]   = 1'b0;
                q_n_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            q    <= RST_VAL;
            q_n  <= ~RST_VAL;
            snap <= '0;
            irq  <= 1'b0;
            prev <= '1;
        end else if (bus.i_CEN) begin
            q    <= q_nxt;
            q_n  <= q_n_nxt;
            // snapshot takes pre-update state, so a same-cycle set stays pending
            if (bus.i_RDCLR) snap <= q;
            irq  <= |(q_nxt & bus.i_IE);
            prev <= bus.i_S;
        end
    end

    assign bus.o_Q    = q;
    assign bus.o_Q_n  = q_n;
    assign bus.o_SNAP = snap;
    assign bus.o_IRQ  = irq;
endmodule
